// File: rtl/core_memory_pkg.sv
// core_memory_pkg: shared types and helpers for the core memory controller.
// State encoding, default local region and the byte-lane masking function.
package core_memory_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SRAM_ACCESS  = 3'd1,
    SRAM_RESPOND = 3'd2,
    WB_ACCESS    = 3'd3,
    RESPOND      = 3'd4
  } mem_state_e;

  localparam logic [7:0] LOCAL_REGION_DEFAULT = 8'h00;

  function automatic logic [31:0] lane_mask(
    input logic [31:0] data,
    input logic [3:0]  sel
  );
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? data[8*i +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/core_memory_controller.sv
// core_memory_controller: routes core requests to local SRAM or Wishbone.
// Optional CORE_MEM_TIMEOUT_EN adds a Wishbone timeout and sticky busError.
module core_memory_controller
  import core_memory_pkg::*;
#(
  parameter int         SRAM_ADDRESS_BITS = 9,
  parameter logic [7:0] LOCAL_REGION      = LOCAL_REGION_DEFAULT,
  parameter int         TIMEOUT_CYCLES    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  core_address,
  input  logic [3:0]                   core_byteSelect,
  input  logic                         core_writeEnable,
  input  logic                         core_readEnable,
  input  logic [31:0]                  core_dataWrite,
  output logic [31:0]                  core_dataRead,
  output logic                         core_busy,
  output logic                         sram_csb,
  output logic                         sram_web,
  output logic [3:0]                   sram_wmask,
  output logic [SRAM_ADDRESS_BITS-1:0] sram_addr,
  output logic [31:0]                  sram_din,
  input  logic [31:0]                  sram_dout,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  output logic                         wb_we_o,
  output logic [3:0]                   wb_sel_o,
  output logic [31:0]                  wb_adr_o,
  output logic [31:0]                  wb_data_o,
  input  logic [31:0]                  wb_data_i,
  input  logic                         wb_ack_i,
  output logic                         busError
);

  mem_state_e  state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req;
  logic        unused_addr_lsbs;

  assign req = core_readEnable | core_writeEnable;
  assign unused_addr_lsbs = ^core_address[1:0];

`ifdef CORE_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] count_q, count_d;
  logic          bus_error_q, bus_error_d;

  // Timeout counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      bus_error_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign busError = bus_error_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign busError = 1'b0;
`endif

  // State and captured request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: capture request in IDLE, wait for ack or timeout on Wishbone
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
`ifdef CORE_MEM_TIMEOUT_EN
    count_d     = '0;
    bus_error_d = bus_error_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = core_address[31:2];
          sel_d   = core_byteSelect;
          wdata_d = core_dataWrite;
          we_d    = core_writeEnable;
          if (core_address[31:24] == LOCAL_REGION) begin
            state_d = SRAM_ACCESS;
          end else begin
            state_d = WB_ACCESS;
          end
        end
      end
      SRAM_ACCESS:  state_d = SRAM_RESPOND;
      SRAM_RESPOND: state_d = IDLE;
      WB_ACCESS: begin
        if (wb_ack_i) begin
          rdata_d = lane_mask(wb_data_i, sel_q);
          state_d = RESPOND;
        end
`ifdef CORE_MEM_TIMEOUT_EN
        else if (count_q == TO_LAST) begin
          rdata_d     = 32'hFFFF_FFFF;
          bus_error_d = 1'b1;
          state_d     = RESPOND;
        end else begin
          count_d = count_q + 1'b1;
        end
`endif
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    sram_csb      = 1'b1;
    sram_web      = 1'b1;
    sram_wmask    = '0;
    sram_addr     = addr_q[SRAM_ADDRESS_BITS+1:2];
    sram_din      = wdata_q;
    wb_cyc_o      = 1'b0;
    wb_stb_o      = 1'b0;
    wb_we_o       = 1'b0;
    wb_sel_o      = '0;
    wb_adr_o      = {addr_q, 2'b00};
    wb_data_o     = wdata_q;
    core_busy     = 1'b0;
    core_dataRead = '0;
    unique case (state_q)
      SRAM_ACCESS: begin
        sram_csb   = 1'b0;
        sram_web   = ~we_q;
        sram_wmask = sel_q;
      end
      SRAM_RESPOND: begin
        core_busy     = req;
        core_dataRead = we_q ? 32'h0 : lane_mask(sram_dout, sel_q);
      end
      WB_ACCESS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = we_q;
        wb_sel_o = sel_q;
      end
      RESPOND: begin
        core_busy     = req;
        core_dataRead = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_memory_controller.sv
// tb_core_memory_controller: scoreboard bench for the core memory controller.
// Includes an SRAM model and a Wishbone slave with programmable ack delay.
module tb_core_memory_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] core_address = '0;
  logic [3:0]  core_byteSelect = '0;
  logic        core_writeEnable = 1'b0;
  logic        core_readEnable = 1'b0;
  logic [31:0] core_dataWrite = '0;
  logic [31:0] core_dataRead;
  logic        core_busy;
  logic        sram_csb, sram_web;
  logic [3:0]  sram_wmask;
  logic [8:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_data_o;
  logic [31:0] wb_data_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        busError;

  core_memory_controller dut (
    .clk(clk), .rst(rst),
    .core_address(core_address), .core_byteSelect(core_byteSelect),
    .core_writeEnable(core_writeEnable), .core_readEnable(core_readEnable),
    .core_dataWrite(core_dataWrite), .core_dataRead(core_dataRead),
    .core_busy(core_busy),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_data_o(wb_data_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .busError(busError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  // SRAM model: 1-cycle read latency, byte-masked writes
  logic [31:0] mem [512];
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int i = 0; i < 4; i++)
          if (sram_wmask[i]) mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
      end
      sram_dout <= mem[sram_addr];
    end
  end

  // Wishbone slave: ack after ack_delay strobed cycles; -1 never acks
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] slave_data = '0;
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      if (ack_delay >= 0 && wait_cnt >= ack_delay) begin
        wb_ack_i  = 1'b1;
        wb_data_i = slave_data;
      end else begin
        wait_cnt++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
    end
  end

  // Bus observers
  logic [8:0]  o_sram_addr;
  logic        o_sram_web;
  logic [3:0]  o_sram_wmask;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic        o_wb_we, o_stb_bad;
  logic [3:0]  o_wb_sel;
  always @(negedge clk) begin
    if (!sram_csb) begin
      o_sram_addr  = sram_addr;
      o_sram_web   = sram_web;
      o_sram_wmask = sram_wmask;
    end
    if (wb_cyc_o) begin
      o_wb_adr = wb_adr_o;
      o_wb_dat = wb_data_o;
      o_wb_we  = wb_we_o;
      o_wb_sel = wb_sel_o;
    end
    if (wb_cyc_o !== wb_stb_o) o_stb_bad = 1'b1;
  end

  task automatic clear_obs();
    o_sram_addr = 'x; o_sram_web = 1'bx; o_sram_wmask = 'x;
    o_wb_adr = 'x; o_wb_dat = 'x; o_wb_we = 1'bx; o_wb_sel = 'x;
    o_stb_bad = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
    core_writeEnable = we;
    core_readEnable  = ~we;
    core_address     = a;
    core_byteSelect  = s;
    core_dataWrite   = d;
  endtask

  task automatic idle_req();
    core_writeEnable = 1'b0;
    core_readEnable  = 1'b0;
  endtask

  int          bcyc;
  bit          bseen;
  logic [31:0] bdata;
  task automatic wait_busy(input int max);
    bcyc = 0; bseen = 0; bdata = '0;
    while (!bseen && bcyc < max) begin
      @(negedge clk);
      bcyc++;
      if (core_busy === 1'b1) begin
        bseen = 1;
        bdata = core_dataRead;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (core_busy !== 1'b0) p++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({sram_csb, sram_web, core_busy, wb_cyc_o, wb_stb_o, wb_we_o, busError} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 1100000",
        {sram_csb, sram_web, core_busy, wb_cyc_o, wb_stb_o, wb_we_o, busError});
    end
    checks++;
    if ({sram_addr, sram_wmask, sram_din, wb_sel_o, wb_adr_o, wb_data_o, core_dataRead} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h adr=%h din=%h dr=%h want 0",
        sram_addr, wb_adr_o, sram_din, core_dataRead);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sram_write_read();
    logic [31:0] exp;
    int p;
    clear_obs();
    @(negedge clk);
    drive_req(1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF);
    sb.push_back(32'h0);
    wait_busy(10);
    idle_req();
    exp = sb.pop_front();
    checks++;
    if (!bseen || bcyc != 2 || bdata !== exp) begin
      errors++;
      $display("FAIL sram_write: seen=%0d cyc=%0d data=%h want cyc=2 data=%h", bseen, bcyc, bdata, exp);
    end
    checks++;
    if (o_sram_addr !== 9'd4 || o_sram_web !== 1'b0 || o_sram_wmask !== 4'hF) begin
      errors++;
      $display("FAIL sram_write_ctrl: addr=%0d web=%b mask=%h want 4 0 f", o_sram_addr, o_sram_web, o_sram_wmask);
    end
    count_pulses(2, p);
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL sram_write_pulses: got %0d extra want 0", p);
    end
    clear_obs();
    drive_req(1'b0, 32'h0000_0010, 4'hF, 32'h0);
    sb.push_back(32'hDEADBEEF);
    wait_busy(10);
    idle_req();
    exp = sb.pop_front();
    checks++;
    if (!bseen || bcyc != 2 || bdata !== exp) begin
      errors++;
      $display("FAIL sram_read: seen=%0d cyc=%0d data=%h want cyc=2 data=%h", bseen, bcyc, bdata, exp);
    end
    checks++;
    if (o_sram_addr !== 9'd4 || o_sram_web !== 1'b1) begin
      errors++;
      $display("FAIL sram_read_ctrl: addr=%0d web=%b want 4 1", o_sram_addr, o_sram_web);
    end
  endtask

  task automatic test_sram_lanes();
    logic [31:0] exp;
    @(negedge clk);
    drive_req(1'b0, 32'h0000_0010, 4'b0100, 32'h0);
    sb.push_back(32'h00AD_0000);
    wait_busy(10);
    idle_req();
    exp = sb.pop_front();
    checks++;
    if (!bseen || bdata !== exp) begin
      errors++;
      $display("FAIL sram_lanes: got %h want %h", bdata, exp);
    end
  endtask

  task automatic test_sram_alias();
    logic [31:0] exp;
    clear_obs();
    @(negedge clk);
    drive_req(1'b0, 32'h00FF_0810, 4'hF, 32'h0);
    sb.push_back(32'hDEADBEEF);
    wait_busy(10);
    idle_req();
    exp = sb.pop_front();
    checks++;
    if (!bseen || bdata !== exp || o_sram_addr !== 9'd4) begin
      errors++;
      $display("FAIL sram_alias: data=%h addr=%0d want %h 4", bdata, o_sram_addr, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    @(negedge clk);
    drive_req(1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344);
    sb.push_back(32'h0);
    wait_busy(10);
    exp = sb.pop_front();
    checks++;
    if (!bseen || bdata !== exp) begin
      errors++;
      $display("FAIL b2b_first: got %h want %h", bdata, exp);
    end
    drive_req(1'b0, 32'h0000_0020, 4'hF, 32'h0);
    sb.push_back(32'h1122_3344);
    wait_busy(10);
    idle_req();
    exp = sb.pop_front();
    checks++;
    if (!bseen || bcyc != 3 || bdata !== exp) begin
      errors++;
      $display("FAIL b2b_second: cyc=%0d data=%h want cyc=3 data=%h", bcyc, bdata, exp);
    end
  endtask

  task automatic test_wb_read();
    logic [31:0] exp;
    int p;
    clear_obs();
    ack_delay = 3;
    slave_data = 32'h1234_5678;
    @(negedge clk);
    drive_req(1'b0, 32'h3000_0004, 4'hF, 32'h0);
    sb.push_back(32'h1234_5678);
    wait_busy(20);
    idle_req();
    exp = sb.pop_front();
    checks++;
    if (!bseen || bcyc != 5 || bdata !== exp) begin
      errors++;
      $display("FAIL wb_read: cyc=%0d data=%h want cyc=5 data=%h", bcyc, bdata, exp);
    end
    checks++;
    if (o_wb_adr !== 32'h3000_0004 || o_wb_we !== 1'b0 || o_stb_bad) begin
      errors++;
      $display("FAIL wb_read_bus: adr=%h we=%b stb_bad=%b want 30000004 0 0", o_wb_adr, o_wb_we, o_stb_bad);
    end
    count_pulses(3, p);
    checks++;
    if (p != 0 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL wb_read_after: pulses=%0d cyc=%b want 0 0", p, wb_cyc_o);
    end
    ack_delay = 0;
    slave_data = 32'hAABB_CCDD;
    drive_req(1'b0, 32'h3000_0007, 4'b1000, 32'h0);
    sb.push_back(32'hAA00_0000);
    wait_busy(10);
    idle_req();
    exp = sb.pop_front();
    checks++;
    if (!bseen || bcyc != 2 || bdata !== exp) begin
      errors++;
      $display("FAIL wb_read_min: cyc=%0d data=%h want cyc=2 data=%h", bcyc, bdata, exp);
    end
    checks++;
    if (o_wb_adr !== 32'h3000_0004) begin
      errors++;
      $display("FAIL wb_adr_align: got %h want 30000004", o_wb_adr);
    end
  endtask

  task automatic test_wb_write();
    int p;
    clear_obs();
    ack_delay = 1;
    slave_data = 32'h0;
    @(negedge clk);
    drive_req(1'b1, 32'h3000_0008, 4'b0011, 32'hCAFE_F00D);
    wait_busy(10);
    idle_req();
    count_pulses(3, p);
    checks++;
    if (!bseen || bcyc != 3 || p != 0) begin
      errors++;
      $display("FAIL wb_write_busy: seen=%0d cyc=%0d extra=%0d want 1 3 0", bseen, bcyc, p);
    end
    checks++;
    if (o_wb_we !== 1'b1 || o_wb_sel !== 4'b0011 || o_wb_dat !== 32'hCAFE_F00D || o_wb_adr !== 32'h3000_0008) begin
      errors++;
      $display("FAIL wb_write_bus: we=%b sel=%b dat=%h adr=%h want 1 0011 cafef00d 30000008",
        o_wb_we, o_wb_sel, o_wb_dat, o_wb_adr);
    end
  endtask

  task automatic test_wb_dropped();
    int p;
    int n;
    ack_delay = 2;
    @(negedge clk);
    drive_req(1'b0, 32'h4000_0000, 4'hF, 32'h0);
    n = 0;
    while (wb_cyc_o !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    idle_req();
    count_pulses(6, p);
    checks++;
    if (n == 5 || p != 0 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL wb_dropped: wait=%0d pulses=%0d cyc=%b want <5 0 0", n, p, wb_cyc_o);
    end
  endtask

`ifdef CORE_MEM_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] exp;
    int p;
    ack_delay = -1;
    @(negedge clk);
    checks++;
    if (busError !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pre: busError=%b want 0", busError);
    end
    drive_req(1'b0, 32'h6000_0000, 4'hF, 32'h0);
    sb.push_back(32'hFFFF_FFFF);
    wait_busy(40);
    idle_req();
    exp = sb.pop_front();
    checks++;
    if (!bseen || bcyc != 17 || bdata !== exp) begin
      errors++;
      $display("FAIL timeout: cyc=%0d data=%h want cyc=17 data=%h", bcyc, bdata, exp);
    end
    count_pulses(5, p);
    checks++;
    if (busError !== 1'b1 || wb_cyc_o !== 1'b0 || p != 0) begin
      errors++;
      $display("FAIL timeout_sticky: busError=%b cyc=%b pulses=%0d want 1 0 0", busError, wb_cyc_o, p);
    end
  endtask
`endif

  task automatic test_reset_mid_wb();
    int p;
    int n;
    ack_delay = -1;
    @(negedge clk);
    drive_req(1'b0, 32'h5000_0000, 4'hF, 32'h0);
    n = 0;
    while (wb_cyc_o !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (n == 5 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wb: wait=%0d cyc=%b stb=%b want <5 0 0", n, wb_cyc_o, wb_stb_o);
    end
    idle_req();
    @(negedge clk);
    rst = 1'b0;
    count_pulses(4, p);
    checks++;
    if (p != 0 || busError !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wb_after: pulses=%0d busError=%b want 0 0", p, busError);
    end
  endtask

  initial begin
    test_reset();
    test_sram_write_read();
    test_sram_lanes();
    test_sram_alias();
    test_back_to_back();
    test_wb_read();
    test_wb_write();
    test_wb_dropped();
`ifdef CORE_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wb();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
